// File: rtl/tx_framer.sv
// tx_framer: buffers encrypted payload words in a FIFO and emits frames of
// one sync/count header word followed by C_PAYLOAD_WORDS payload words.
//
// Handshake semantics (both AXI-Stream sides): a word transfers on a rising
// clock edge where tvalid and tready are both 1. Once m_axis_tvalid is raised
// it stays raised, with tdata/sof/tlast stable, until that transfer happens.
// m_axis_tvalid/tdata/sof/tlast come only from registers (state, beat counter,
// FIFO storage), and s_axis_tready comes only from the registered level.
module tx_framer #(
    parameter int          C_PAYLOAD_WORDS = 16,
    parameter int          C_FIFO_DEPTH    = 32,
    parameter logic [15:0] C_SYNC_WORD     = 16'hA5C3
) (
    input  logic                            i_aclk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [31:0]                     s_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [31:0]                     m_axis_tdata,
    output logic                            m_axis_sof,
    output logic                            m_axis_tlast,
    output logic [15:0]                     o_frame_count,
    output logic [$clog2(C_FIFO_DEPTH):0]   o_fifo_level,
    output logic [1:0]                      dbg_state
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     mem [C_FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [LW-1:0]   beat_cnt;
    logic [15:0]     frame_count;
    logic            full;
    logic            wr_en;
    logic            rd_en;
    logic            last_beat;

    assign full          = (level == LW'(C_FIFO_DEPTH));
    assign s_axis_tready = ~full;
    // A full FIFO refuses the write even when a pop happens in the same cycle.
    assign wr_en         = s_axis_tvalid & ~full;
    assign rd_en         = (state_q == PAYLOAD) & m_axis_tready;
    assign last_beat     = (beat_cnt == LW'(C_PAYLOAD_WORDS - 1));
    assign o_fifo_level  = level;
    assign o_frame_count = frame_count;
    assign dbg_state     = state_q;

    // FIFO storage: no reset needed, the level qualifies every entry.
    always_ff @(posedge i_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FSM state register, beat counter and completed-frame counter.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            beat_cnt    <= '0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == HEADER && m_axis_tready) begin
                beat_cnt <= '0;
            end else if (rd_en) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + LW'(1);
            end
            if (rd_en && last_beat) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Next state and output decode; outputs depend only on registered values.
    always_comb begin
        state_d       = state_q;
        m_axis_tvalid = 1'b0;
        m_axis_sof    = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = 32'd0;
        case (state_q)
            IDLE: begin
                if (i_enable && (level >= LW'(C_PAYLOAD_WORDS))) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_sof    = 1'b1;
                m_axis_tdata  = {C_SYNC_WORD, frame_count};
                if (m_axis_tready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = last_beat;
                m_axis_tdata  = mem[rd_ptr];
                if (m_axis_tready && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer (4-word frames, 8-word FIFO): directed scenarios plus a
// randomized phase, checked every cycle against a queue-based frame model.
module tb_tx_framer;

    localparam int          PW    = 4;
    localparam int          DEPTH = 8;
    localparam logic [15:0] SYNC  = 16'hA5C3;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = 32'd0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic        m_sof;
    logic        m_tlast;
    logic [15:0] frame_count;
    logic [3:0]  fifo_level;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: words held in the FIFO, frame progress, completed frames.
    logic [31:0] exp_q[$];
    logic [33:0] cap_q[$];
    logic [15:0] cnt_m = 16'd0;
    bit          in_frame = 0;
    int          idx = 0;
    bit          gap = 0;
    bit          p_rst = 1;
    bit          p_en = 0;
    int          p_lvl = 0;
    int          hdr_seen = 0;
    int          pay_seen = 0;
    int          force_cnt = 0;
    int          force_seen = 0;

    tx_framer #(
        .C_PAYLOAD_WORDS (PW),
        .C_FIFO_DEPTH    (DEPTH),
        .C_SYNC_WORD     (SYNC)
    ) dut (
        .i_aclk        (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_sof    (m_sof),
        .m_axis_tlast  (m_tlast),
        .o_frame_count (frame_count),
        .o_fifo_level  (fifo_level),
        .dbg_state     (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: at each negedge check outputs against the model, then apply
    // the transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        bit start;
        bit wr;
        if (p_rst) begin
            exp_q.delete();
            cnt_m    = 16'd0;
            in_frame = 0;
            idx      = 0;
            gap      = 0;
        end
        if (force_cnt != force_seen) begin
            cnt_m      = 16'hFFFF;
            force_seen = force_cnt;
        end
        start = !p_rst && !gap && !in_frame && p_en && (p_lvl >= PW);
        if (start) begin
            in_frame = 1;
            idx      = 0;
        end
        gap = 0;
        chk("tvalid", 32'(m_tvalid), 32'(in_frame));
        chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("s_tready", 32'(s_tready), 32'(exp_q.size() < DEPTH));
        chk("frame_count", 32'(frame_count), 32'(cnt_m));
        if (in_frame && m_tvalid) begin
            if (idx == 0) begin
                chk("hdr_data", m_tdata, {SYNC, cnt_m});
                chk("hdr_sof", 32'(m_sof), 32'd1);
                chk("hdr_tlast", 32'(m_tlast), 32'd0);
            end else begin
                chk("pay_data", m_tdata, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
                chk("pay_sof", 32'(m_sof), 32'd0);
                chk("pay_tlast", 32'(m_tlast), 32'(idx == PW));
            end
        end
        p_rst = i_reset;
        p_en  = i_enable;
        p_lvl = exp_q.size();
        if (!i_reset) begin
            wr = s_tvalid && (exp_q.size() < DEPTH);
            if (in_frame && m_tready) begin
                if (idx == 0) begin
                    cap_q.push_back({1'b1, 1'b0, SYNC, cnt_m});
                    hdr_seen++;
                    idx = 1;
                end else if (exp_q.size() > 0) begin
                    cap_q.push_back({1'b0, 1'(idx == PW), exp_q.pop_front()});
                    pay_seen++;
                    if (idx == PW) begin
                        cnt_m    = cnt_m + 16'd1;
                        in_frame = 0;
                        gap      = 1;
                        idx      = 0;
                    end else begin
                        idx++;
                    end
                end
            end
            if (wr) exp_q.push_back(s_tdata);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        bit acc = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = s_tready && !i_reset;
            tick();
        end
        s_tvalid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pay(input int target);
        int k = 0;
        while (pay_seen < target && k < 300) begin
            tick();
            k++;
        end
        if (pay_seen < target) chk("wait_payload_timeout", 32'(pay_seen), 32'(target));
    endtask

    task automatic wait_hdr(input int target);
        int k = 0;
        while (hdr_seen < target && k < 300) begin
            tick();
            k++;
        end
        if (hdr_seen < target) chk("wait_header_timeout", 32'(hdr_seen), 32'(target));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        int base;
        int capb;
        tick();
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        chk("rst_count", 32'(frame_count), 32'd0);
        tick();

        // Nominal frame: header 0xA5C30000 then 1..4, tlast on 4.
        capb     = cap_q.size();
        i_enable = 1'b1;
        m_tready = 1'b1;
        for (int w = 1; w <= 4; w++) send_word(32'(w));
        wait_pay(4);
        repeat (2) tick();
        chk("nom_beats", 32'(cap_q.size() - capb), 32'd5);
        if (cap_q.size() - capb == 5) begin
            chk("nom_hdr", 32'(cap_q[capb][31:0]), 32'hA5C3_0000);
            chk("nom_hdr_sof", 32'(cap_q[capb][33]), 32'd1);
            chk("nom_w1", cap_q[capb+1][31:0], 32'h1);
            chk("nom_w3_last", 32'(cap_q[capb+3][32]), 32'd0);
            chk("nom_w4", cap_q[capb+4][31:0], 32'h4);
            chk("nom_w4_last", 32'(cap_q[capb+4][32]), 32'd1);
        end
        @(negedge clk);
        chk("nom_count", 32'(frame_count), 32'd1);
        tick();

        // Backpressure on header and on the 2nd payload word.
        m_tready = 1'b0;
        base     = hdr_seen;
        for (int w = 0; w < 4; w++) send_word($urandom);
        begin
            int k = 0;
            while (!m_tvalid && k < 50) begin tick(); k++; end
        end
        repeat (5) tick();
        m_tready = 1'b1;
        tick();
        tick();
        m_tready = 1'b0;
        repeat (5) tick();
        m_tready = 1'b1;
        wait_pay(8);
        chk("bp_headers", 32'(hdr_seen - base), 32'd1);
        tick();

        // Full FIFO with enable low; 9th word waits for a pop.
        i_enable = 1'b0;
        for (int w = 0; w < 8; w++) send_word(32'h100 + 32'(w));
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_tready", 32'(s_tready), 32'd0);
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 32'h108;
        repeat (3) tick();
        @(negedge clk);
        chk("full_no_write", 32'(fifo_level), 32'd8);
        tick();
        i_enable = 1'b1;
        send_word(32'h108);
        send_word(32'h109);
        wait_pay(16);
        tick();

        // Enable drop after the header handshake.
        base = hdr_seen;
        send_word($urandom);
        send_word($urandom);
        wait_hdr(base + 1);
        i_enable = 1'b0;
        for (int w = 0; w < 4; w++) send_word($urandom);
        wait_pay(20);
        repeat (20) tick();
        chk("drop_one_header", 32'(hdr_seen - base), 32'd1);

        // Frame counter wrap.
        do_reset();
        force dut.frame_count = 16'hFFFF;
        force_cnt++;
        tick();
        release dut.frame_count;
        tick();
        capb     = cap_q.size();
        i_enable = 1'b1;
        for (int w = 0; w < 4; w++) send_word($urandom);
        wait_pay(pay_seen + 4);
        tick();
        if (cap_q.size() > capb) chk("wrap_hdr", cap_q[capb][31:0], 32'hA5C3_FFFF);
        else chk("wrap_hdr_missing", 32'd0, 32'd1);
        @(negedge clk);
        chk("wrap_count", 32'(frame_count), 32'd0);
        tick();

        // Reset after two payload beats.
        base = pay_seen;
        for (int w = 0; w < 4; w++) send_word($urandom);
        wait_pay(base + 2);
        i_enable = 1'b0;
        i_reset  = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        chk("mrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mrst_level", 32'(fifo_level), 32'd0);
        chk("mrst_count", 32'(frame_count), 32'd0);
        tick();

        // Randomized traffic on both sides.
        fork
            for (int c = 0; c < 3000; c++) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = $urandom;
                i_enable = ($urandom_range(0, 7) != 0);
                tick();
            end
            for (int c = 0; c < 3000; c++) begin
                m_tready = ($urandom_range(0, 2) != 0);
                tick();
            end
        join
        s_tvalid = 1'b0;
        i_enable = 1'b1;
        m_tready = 1'b1;
        repeat (60) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
